reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//   In-order completion buffer for the out-of-order core. The dispatcher allocates up to
//   2 entries/cycle. Arithmetic/other stations write results via CDB entries
//   (cdb_entry_t: valid, rob_id, rd_v). The block commits up to 2 entries/cycle in program
//   order to the regfile/RAT. Accepted results are re-broadcast to the stations' broadcast ports.
// PARAMETERS
//   INDEX_WIDTH     5  log2 depth; DEPTH = 1<<INDEX_WIDTH = 32; matches 5-bit rob_id
//   WRITE_PORTS_IN  2  CDB write ports from functional units
// PORTS
//   clk            in   1      one clock
//   rst_n          in   1      reset is asynchronous and active-low
//   flush          in   1      sync squash of all entries
//   alloc_req[2]   in   1      allocation request; [1] honoured only with [0]
//   alloc_rd[2]    in   5      destination arch register per request
//   alloc_id[2]    out  5      rob_id granted to request 0/1 (tail, tail+1)
//   full[2]        out  1      full[0]: 0 free; full[1]: <2 free
//   cdb_in[W]      in   cdb_entry_t  result writes, W = WRITE_PORTS_IN
//   rd_id[4]       in   5      operand lookup (2 srcs x 2 dispatch slots)
//   rd_ready[4]    out  1      entry done, or being written on cdb_in this cycle
//   rd_value[4]    out  32     stored value, or cdb bypass value
//   broadcast[W]   out  cdb_entry_t  registered copy of accepted cdb_in writes
//   commit_valid[2] out 1      retire strobe, slot 0 = oldest
//   commit_rd[2]   out  5      arch destination (0 = no write)
//   commit_v[2]    out  32     value to write
//   commit_id[2]   out  5      rob_id retired (RAT clears matching mapping)
// BEHAVIOUR
//   - State: entries {valid, done, rd, value}; head/tail with extra wrap bit; count 0..DEPTH.
//   - Reset (async, rst_n=0): all entries invalid; head=tail=count=0; broadcast and commit_*
//     outputs 0. full=0, alloc_id={0,1}.
//   - Allocation at posedge if alloc_req[k] and !full[k]. Entry gets valid=1, done=0, rd=alloc_rd.
//     Tail advances by grants, modulo DEPTH.
//   - full[] uses current count only; same-cycle commits never free space for allocation.
//   - CDB write: valid port whose rob_id hits a valid, !done entry sets done=1, value=rd_v
//     at the next edge. Hits on an invalid or already-done entry are ignored (no broadcast).
//   - Two ports with the same rob_id in one cycle: the lowest port wins; simulation asserts this.
//   - broadcast[j] <= accepted ? cdb_in[j] : 0 (1-cycle latency).
//   - Commit: decided from state at cycle start.
//     - Slot0 retires if head valid&done.
//     - Slot1 retires if slot0 retires and head+1 valid&done.
//     - Retired entries are invalidated; head and count update at the same edge.
//     - commit_* are registered: visible the cycle after the decision, one-cycle strobes.
//   - Latency: CDB write in cycle N gives done at N+1 and commit_valid at N+2 at the earliest.
//   - rd_* lookup is combinational, priority cdb_in (lowest port) > stored done entry.
//     rd_ready=0 for not-done or invalid ids.
//   - Simultaneous events at one edge are legal: alloc+commit+CDB. count = count + grants - retires.
//     Wrap-around of head/tail is via modulo DEPTH. At count=DEPTH, tail==head with differing wrap bit.
//   - flush: priority over alloc/CDB/commit. Next edge: all invalid, head=tail=count=0,
//     commit_*/broadcast 0.
//   - Async reset mid-operation discards everything immediately, as for reset.
// STRUCTURE
//   - rv32cpu_type package gets: rob_entry_t {valid, done, rd[4:0], value[31:0]};
//     ROB_INDEX_WIDTH=5. cdb_entry_t is reused unchanged.
//   - Single module, no sub-module. Pointer/count logic and commit select are small enough to inline.
// TESTING
//   1. Reset, alloc 2 (rd=3,rd=4) -> alloc_id={0,1}; next cycle count=2, full={0,0}, no commit.
//   2. CDB {1,id1,0xAA} then {1,id0,0x55} -> one cycle later commit both:
//      slot0 rd=3 v=0x55, slot1 rd=4 v=0xAA.
//   3. Out-of-order: id1 done, id0 not -> no commit.
//      CDB id0 -> both retire same cycle, in order.
//   4. Fill 32 entries -> full={1,1}; at 31 -> full={0,1}.
//      Alloc with commit in the same cycle: count stays constant.
//      Tail wraps 31->0 correctly.
//   5. rd_id=id of entry written on cdb_in this cycle -> rd_ready=1, rd_value=cdb value.
//      Write to an invalid id -> ignored, broadcast 0.
//   6. flush with pending CDB and alloc -> next cycle count=0, commit_valid=0.
//      rst_n low mid-stream -> outputs 0 asynchronously.

Source files
------------

// File: rtl/rv32cpu_type.sv
// Shared types for the rv32 out-of-order core: CDB result packets and ROB entries.
package rv32cpu_type;

    localparam int unsigned ROB_INDEX_WIDTH = 5;

    typedef struct packed {
        logic                       valid;
        logic [ROB_INDEX_WIDTH-1:0] rob_id;
        logic [31:0]                rd_v;
    } cdb_entry_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic [4:0]  rd;
        logic [31:0] value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order completion buffer: dual allocate, multi-port CDB completion with operand
// bypass, dual in-order commit, and registered re-broadcast of accepted results.
module reorder_buffer
    import rv32cpu_type::*;
#(
    parameter int unsigned INDEX_WIDTH    = ROB_INDEX_WIDTH,
    parameter int unsigned WRITE_PORTS_IN = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   alloc_req    [2],
    input  logic [4:0]             alloc_rd     [2],
    output logic [INDEX_WIDTH-1:0] alloc_id     [2],
    output logic                   full         [2],
    input  cdb_entry_t             cdb_in       [WRITE_PORTS_IN],
    input  logic [INDEX_WIDTH-1:0] rd_id        [4],
    output logic                   rd_ready     [4],
    output logic [31:0]            rd_value     [4],
    output cdb_entry_t             broadcast    [WRITE_PORTS_IN],
    output logic                   commit_valid [2],
    output logic [4:0]             commit_rd    [2],
    output logic [31:0]            commit_v     [2],
    output logic [INDEX_WIDTH-1:0] commit_id    [2]
);

    localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
    localparam int unsigned W     = WRITE_PORTS_IN;

    typedef logic [INDEX_WIDTH-1:0] idx_t;
    typedef logic [INDEX_WIDTH:0]   ptr_t;

    rob_entry_t rob [DEPTH];
    ptr_t       head, tail, count;
    idx_t       head_idx, tail_idx, tail1_idx;
    idx_t       slot_idx [2];
    logic       grant    [2];
    logic       retire   [2];
    logic       accept   [W];
    logic       byp      [4];
    logic [1:0] n_grant, n_retire;
    logic       dup_hit;

    always_comb begin
        head_idx    = head[INDEX_WIDTH-1:0];
        tail_idx    = tail[INDEX_WIDTH-1:0];
        tail1_idx   = tail_idx + idx_t'(1);
        slot_idx[0] = head_idx;
        slot_idx[1] = head_idx + idx_t'(1);
    end

    assign alloc_id[0] = tail_idx;
    assign alloc_id[1] = tail1_idx;
    assign full[0]     = (count == ptr_t'(DEPTH));
    assign full[1]     = (count >= ptr_t'(DEPTH - 1));

    always_comb begin
        grant[0]  = alloc_req[0] && !full[0];
        grant[1]  = alloc_req[0] && alloc_req[1] && !full[1];
        retire[0] = rob[slot_idx[0]].valid && rob[slot_idx[0]].done;
        retire[1] = retire[0] && rob[slot_idx[1]].valid && rob[slot_idx[1]].done;
        n_grant   = {1'b0, grant[0]} + {1'b0, grant[1]};
        n_retire  = {1'b0, retire[0]} + {1'b0, retire[1]};
    end

    // A port loses to any lower port carrying the same rob_id.
    always_comb begin
        dup_hit = 1'b0;
        for (int unsigned j = 0; j < W; j++) begin
            accept[j] = cdb_in[j].valid && rob[cdb_in[j].rob_id].valid
                        && !rob[cdb_in[j].rob_id].done;
            for (int unsigned k = 0; k < j; k++) begin
                if (cdb_in[k].valid && cdb_in[j].valid
                    && (cdb_in[k].rob_id == cdb_in[j].rob_id)) begin
                    accept[j] = 1'b0;
                    dup_hit   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            byp[i]      = 1'b0;
            rd_ready[i] = rob[rd_id[i]].valid && rob[rd_id[i]].done;
            rd_value[i] = rob[rd_id[i]].value;
            for (int unsigned j = 0; j < W; j++) begin
                if (!byp[i] && accept[j] && (cdb_in[j].rob_id == rd_id[i])) begin
                    byp[i]      = 1'b1;
                    rd_ready[i] = 1'b1;
                    rd_value[i] = cdb_in[j].rd_v;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) rob[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned s = 0; s < 2; s++) begin
                commit_valid[s] <= 1'b0;
                commit_rd[s]    <= '0;
                commit_v[s]     <= '0;
                commit_id[s]    <= '0;
            end
            for (int unsigned j = 0; j < W; j++) broadcast[j] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) rob[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned s = 0; s < 2; s++) begin
                commit_valid[s] <= 1'b0;
                commit_rd[s]    <= '0;
                commit_v[s]     <= '0;
                commit_id[s]    <= '0;
            end
            for (int unsigned j = 0; j < W; j++) broadcast[j] <= '0;
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                commit_valid[s] <= retire[s];
                commit_rd[s]    <= retire[s] ? rob[slot_idx[s]].rd    : '0;
                commit_v[s]     <= retire[s] ? rob[slot_idx[s]].value : '0;
                commit_id[s]    <= retire[s] ? slot_idx[s]            : '0;
                if (retire[s]) rob[slot_idx[s]].valid <= 1'b0;
            end
            // Allocated slots are always invalid, so they never collide with retiring ones.
            if (grant[0]) rob[tail_idx]  <= '{valid: 1'b1, done: 1'b0, rd: alloc_rd[0], value: '0};
            if (grant[1]) rob[tail1_idx] <= '{valid: 1'b1, done: 1'b0, rd: alloc_rd[1], value: '0};
            for (int unsigned j = 0; j < W; j++) begin
                if (accept[j]) begin
                    rob[cdb_in[j].rob_id].done  <= 1'b1;
                    rob[cdb_in[j].rob_id].value <= cdb_in[j].rd_v;
                end
                broadcast[j] <= accept[j] ? cdb_in[j] : '0;
            end
            head  <= head + ptr_t'(n_retire);
            tail  <= tail + ptr_t'(n_grant);
            count <= count + ptr_t'(n_grant) - ptr_t'(n_retire);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !dup_hit);
    assert property (@(posedge clk) disable iff (!rst_n)
        (count == ptr_t'(DEPTH)) == ((head ^ tail) == {1'b1, {INDEX_WIDTH{1'b0}}}));
    assert property (@(posedge clk) disable iff (!rst_n) (count == '0) == (head == tail));

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based program-order model predicts commits,
// broadcasts and lookups; a separate monitor checks the registered outputs.
`timescale 1ns/1ps
module tb_reorder_buffer;
    import rv32cpu_type::*;

    localparam int unsigned W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alloc_req [2];
    logic [4:0]  alloc_rd  [2];
    logic [4:0]  alloc_id  [2];
    logic        full      [2];
    cdb_entry_t  cdb_in    [W];
    logic [4:0]  rd_id     [4];
    logic        rd_ready  [4];
    logic [31:0] rd_value  [4];
    cdb_entry_t  broadcast [W];
    logic        commit_valid [2];
    logic [4:0]  commit_rd [2];
    logic [31:0] commit_v  [2];
    logic [4:0]  commit_id [2];

    always #5 clk = ~clk;

    reorder_buffer #(.INDEX_WIDTH(5), .WRITE_PORTS_IN(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_id(alloc_id), .full(full),
        .cdb_in(cdb_in), .rd_id(rd_id), .rd_ready(rd_ready), .rd_value(rd_value),
        .broadcast(broadcast), .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_v(commit_v), .commit_id(commit_id)
    );

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int unsigned cyc; logic [4:0] id; logic [4:0] rd; logic [31:0] v;} exp_commit_t;
    typedef struct {int unsigned cyc; int unsigned port; cdb_entry_t e;} exp_bcast_t;
    typedef struct {logic [4:0] id; logic [4:0] rd; bit done; logic [31:0] v;} ment_t;

    exp_commit_t exp_c [$];
    exp_bcast_t  exp_b [$];
    ment_t       mq    [$];
    int unsigned mtail = 0;

    logic        s_flush;
    logic        s_req [2];
    logic [4:0]  s_rd  [2];
    cdb_entry_t  s_cdb [W];
    logic [4:0]  s_rid [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
    endtask

    function automatic int find(input logic [4:0] id);
        for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
        return -1;
    endfunction

    // Monitor: registered outputs, checked 1ns after each active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (commit_valid[1] && !commit_valid[0]) flag("commit_slot1_alone");
            for (int s = 0; s < 2; s++) begin
                if (commit_valid[s]) begin
                    if (exp_c.size() == 0) flag("commit_unexpected");
                    else begin
                        exp_commit_t e;
                        e = exp_c.pop_front();
                        chk("commit_cycle", 64'(cyc), 64'(e.cyc));
                        chk("commit_id", commit_id[s], e.id);
                        chk("commit_rd", commit_rd[s], e.rd);
                        chk("commit_v", commit_v[s], e.v);
                    end
                end
            end
            while (exp_c.size() > 0 && exp_c[0].cyc <= cyc) begin
                flag("commit_missing");
                void'(exp_c.pop_front());
            end
            for (int j = 0; j < W; j++) begin
                if (broadcast[j].valid) begin
                    if (exp_b.size() == 0) flag("broadcast_unexpected");
                    else begin
                        exp_bcast_t b;
                        b = exp_b.pop_front();
                        chk("broadcast_cycle", 64'(cyc), 64'(b.cyc));
                        chk("broadcast_port", 64'(j), 64'(b.port));
                        chk("broadcast_data", broadcast[j], b.e);
                    end
                end else begin
                    chk("broadcast_idle", broadcast[j], '0);
                end
            end
            while (exp_b.size() > 0 && exp_b[0].cyc <= cyc) begin
                flag("broadcast_missing");
                void'(exp_b.pop_front());
            end
        end
    end

    task automatic idle_stim();
        s_flush = 1'b0;
        for (int k = 0; k < 2; k++) begin s_req[k] = 1'b0; s_rd[k] = '0; end
        for (int j = 0; j < W; j++) s_cdb[j] = '0;
        for (int i = 0; i < 4; i++) s_rid[i] = '0;
    endtask

    task automatic apply_inputs();
        flush = s_flush;
        for (int k = 0; k < 2; k++) begin alloc_req[k] = s_req[k]; alloc_rd[k] = s_rd[k]; end
        for (int j = 0; j < W; j++) cdb_in[j] = s_cdb[j];
        for (int i = 0; i < 4; i++) rd_id[i] = s_rid[i];
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic drive_cycle();
        bit          acc [W];
        bit          g0, g1, byp;
        int unsigned nret;
        int          idx;
        logic        e_rdy;
        logic [31:0] e_val;
        apply_inputs();
        #1;
        chk("full0", full[0], mq.size() == 32);
        chk("full1", full[1], mq.size() >= 31);
        chk("alloc_id0", alloc_id[0], mtail % 32);
        chk("alloc_id1", alloc_id[1], (mtail + 1) % 32);
        for (int j = 0; j < W; j++) begin
            idx    = find(s_cdb[j].rob_id);
            acc[j] = s_cdb[j].valid && idx >= 0 && !mq[idx].done;
            for (int k = 0; k < j; k++)
                if (s_cdb[k].valid && s_cdb[k].rob_id == s_cdb[j].rob_id) acc[j] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            e_rdy = 1'b0; e_val = '0; byp = 0;
            idx = find(s_rid[i]);
            if (idx >= 0 && mq[idx].done) begin e_rdy = 1'b1; e_val = mq[idx].v; end
            for (int j = 0; j < W; j++)
                if (!byp && acc[j] && s_cdb[j].rob_id == s_rid[i]) begin
                    byp = 1; e_rdy = 1'b1; e_val = s_cdb[j].rd_v;
                end
            chk("rd_ready", rd_ready[i], e_rdy);
            if (e_rdy) chk("rd_value", rd_value[i], e_val);
        end
        g0 = 0; g1 = 0; nret = 0;
        if (!s_flush) begin
            g0 = s_req[0] && mq.size() < 32;
            g1 = s_req[0] && s_req[1] && mq.size() < 31;
            if (mq.size() >= 1 && mq[0].done) nret = 1;
            if (nret == 1 && mq.size() >= 2 && mq[1].done) nret = 2;
            for (int r = 0; r < nret; r++)
                exp_c.push_back('{cyc: cyc + 1, id: mq[r].id, rd: mq[r].rd, v: mq[r].v});
            for (int j = 0; j < W; j++)
                if (acc[j]) exp_b.push_back('{cyc: cyc + 1, port: j, e: s_cdb[j]});
        end
        @(posedge clk);
        if (s_flush) begin
            mq.delete();
            mtail = 0;
        end else begin
            for (int j = 0; j < W; j++)
                if (acc[j]) begin
                    idx = find(s_cdb[j].rob_id);
                    mq[idx].done = 1;
                    mq[idx].v    = s_cdb[j].rd_v;
                end
            for (int r = 0; r < nret; r++) void'(mq.pop_front());
            if (g0) begin mq.push_back('{id: 5'(mtail), rd: s_rd[0], done: 0, v: '0}); mtail = (mtail + 1) % 32; end
            if (g1) begin mq.push_back('{id: 5'(mtail), rd: s_rd[1], done: 0, v: '0}); mtail = (mtail + 1) % 32; end
        end
        @(negedge clk);
    endtask

    task automatic complete_oldest(input int unsigned n);
        int unsigned p = 0;
        for (int i = 0; i < mq.size() && p < n; i++)
            if (!mq[i].done) begin
                s_cdb[p] = '{valid: 1'b1, rob_id: mq[i].id, rd_v: $urandom};
                p++;
            end
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && mq.size() > 0; n++) begin
            idle_stim();
            complete_oldest(2);
            drive_cycle();
        end
        chk("drain_empty", 64'(mq.size()), 64'd0);
    endtask

    task automatic rand_stim(input int unsigned alloc_pct, input int unsigned cdb_pct);
        s_flush = ($urandom_range(0, 99) < 2);
        for (int k = 0; k < 2; k++) begin
            s_req[k] = ($urandom_range(0, 99) < alloc_pct);
            s_rd[k]  = 5'($urandom);
        end
        for (int j = 0; j < W; j++) begin
            s_cdb[j].valid  = ($urandom_range(0, 99) < cdb_pct);
            s_cdb[j].rob_id = (mq.size() > 0 && $urandom_range(0, 3) != 0)
                              ? mq[$urandom_range(0, mq.size() - 1)].id : 5'($urandom);
            s_cdb[j].rd_v   = $urandom;
            for (int k = 0; k < j; k++)
                if (s_cdb[k].valid && s_cdb[k].rob_id == s_cdb[j].rob_id) s_cdb[j].valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0:       s_rid[i] = s_cdb[$urandom_range(0, W - 1)].rob_id;
                1:       s_rid[i] = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].id : 5'($urandom);
                default: s_rid[i] = 5'($urandom);
            endcase
        end
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) chk("rst_commit_valid", commit_valid[s], 1'b0);
        for (int j = 0; j < W; j++) chk("rst_broadcast", broadcast[j], '0);
        chk("rst_full0", full[0], 1'b0);
        chk("rst_full1", full[1], 1'b0);
        chk("rst_alloc_id0", alloc_id[0], 5'd0);
        chk("rst_alloc_id1", alloc_id[1], 5'd1);
        mq.delete(); mtail = 0; exp_c.delete(); exp_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_stim();
        apply_inputs();
        repeat (2) @(negedge clk);
        chk("reset_commit_valid", commit_valid[0], 1'b0);
        chk("reset_broadcast", broadcast[0], '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two allocations, then idle: ids 0/1, no commit.
        idle_stim(); s_req = '{1'b1, 1'b1}; s_rd = '{5'd3, 5'd4}; drive_cycle();
        idle_stim(); drive_cycle();
        // Younger result first on port 0, both bypassed to lookups.
        idle_stim();
        s_cdb[0] = '{valid: 1'b1, rob_id: 5'd1, rd_v: 32'hAA};
        s_cdb[1] = '{valid: 1'b1, rob_id: 5'd0, rd_v: 32'h55};
        s_rid[0] = 5'd1; s_rid[1] = 5'd0; s_rid[2] = 5'd2;
        drive_cycle();
        repeat (2) begin idle_stim(); drive_cycle(); end

        // Out-of-order completion holds until the older entry is done.
        idle_stim(); s_req = '{1'b1, 1'b1}; s_rd = '{5'd7, 5'd8}; drive_cycle();
        idle_stim(); s_cdb[0] = '{valid: 1'b1, rob_id: 5'd3, rd_v: 32'h1234}; drive_cycle();
        repeat (2) begin idle_stim(); drive_cycle(); end
        idle_stim(); s_cdb[1] = '{valid: 1'b1, rob_id: 5'd2, rd_v: 32'h5678}; drive_cycle();
        repeat (2) begin idle_stim(); drive_cycle(); end

        // Fill past the wrap point, probe the 31 and 32 boundaries.
        for (int n = 0; n < 15; n++) begin
            idle_stim(); s_req = '{1'b1, 1'b1}; s_rd = '{5'($urandom), 5'($urandom)}; drive_cycle();
        end
        idle_stim(); s_req[0] = 1'b1; s_rd[0] = 5'd9; drive_cycle();
        idle_stim(); s_req = '{1'b1, 1'b1}; s_rd = '{5'd10, 5'd11}; drive_cycle();
        idle_stim(); s_req = '{1'b1, 1'b1}; complete_oldest(2); drive_cycle();
        idle_stim(); s_req = '{1'b1, 1'b1}; drive_cycle();
        for (int n = 0; n < 6; n++) begin
            idle_stim(); s_req[0] = 1'b1; s_rd[0] = 5'($urandom); complete_oldest(1); drive_cycle();
        end
        drain();

        // Writes to an invalid id and to an already-done entry are dropped.
        idle_stim(); s_cdb[0] = '{valid: 1'b1, rob_id: 5'd9, rd_v: 32'hDEAD}; s_rid[0] = 5'd9; drive_cycle();
        idle_stim(); s_req[0] = 1'b1; s_rd[0] = 5'd12; drive_cycle();
        idle_stim(); complete_oldest(1); drive_cycle();
        idle_stim(); s_cdb[1] = '{valid: 1'b1, rob_id: 5'(find(5'(mtail - 1)) >= 0 ? mtail - 1 : 0), rd_v: 32'hBEEF};
        drive_cycle();
        repeat (2) begin idle_stim(); drive_cycle(); end

        // Flush beats pending allocation and completion.
        idle_stim(); s_req = '{1'b1, 1'b1}; drive_cycle();
        idle_stim(); s_flush = 1'b1; s_req = '{1'b1, 1'b1}; complete_oldest(2); drive_cycle();
        idle_stim(); drive_cycle();

        for (int n = 0; n < 300; n++) begin rand_stim(60, 40); drive_cycle(); end
        async_reset();
        for (int n = 0; n < 300; n++) begin rand_stim(90, 25); drive_cycle(); end
        for (int n = 0; n < 300; n++) begin rand_stim(30, 75); drive_cycle(); end
        s_flush = 1'b0;
        drain();
        repeat (2) begin idle_stim(); drive_cycle(); end
        chk("exp_commit_left", 64'(exp_c.size()), 64'd0);
        chk("exp_bcast_left", 64'(exp_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
